// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file and its pending-write scoreboard.
package regfile_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 5;
  localparam int          ZERO_REG     = 0;
  localparam int          SP_INDEX_DEF = 29;
  localparam logic [31:0] SP_RESET_DEF = 32'h0000_0400;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register plus a registered
// population count, so hazard control can see how many long-latency results are outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pending_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
  always_comb begin
    pending_nxt = pending;
    if (wr_en && (wr_addr != ZERO_ADDR)) pending_nxt[wr_addr] = 1'b0;
    // Set is applied after clear: a freshly issued op stays outstanding over a retiring write.
    if (sb_set && (sb_addr != ZERO_ADDR)) pending_nxt[sb_addr] = 1'b1;
  end

  // Counting the next-state vector keeps busy_cnt aligned with the bits it summarises.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
    end
  end

  // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional same-cycle write bypass, a
// stack-pointer reset value and an integrated pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                NUM_RD   = 2,
  parameter int                SP_INDEX = SP_INDEX_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF),
  parameter int                BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_active;

  assign wr_active = wr_en && (wr_addr != ZERO_ADDR);

  // NOTE: the array is flop-based and reset explicitly, because the stack pointer
  // must come up with a non-zero value; a RAM macro could not be used here.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_active) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .pending  (pending),
    .busy_cnt (busy_cnt)
  );

  // A same-cycle write hides the pending bit even without data bypass, because
  // the result is committed at this edge and the consumer may proceed.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = wr_active && (wr_addr == ra);

    assign rd_data[k*DATA_W +: DATA_W] = (ra == ZERO_ADDR)        ? '0 :
                                         ((BYPASS != 0) && hit)   ? wr_data :
                                                                    mem[ra];
    assign rd_busy[k] = pending[ra] && !hit;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [63:0] rd_data_b,  rd_data_n;
  logic [1:0]  rd_busy_b,  rd_busy_n;
  logic [5:0]  busy_cnt_b, busy_cnt_n;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_cnt(busy_cnt_b)
  );

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_cnt(busy_cnt_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ss;
    logic [4:0]  sa;
    logic [31:0] d0, d1;   // expected data, bypass instance
    logic [31:0] n0, n1;   // expected data, non-bypass instance
    logic        b0, b1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; sb_set = 1'b0; sb_addr = 5'd0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] n0, input logic [31:0] n1,
                           input logic b0, input logic b1, input logic [5:0] cnt);
    check({tag, ".d0"},    rd_data_b[31:0],  d0);
    check({tag, ".d1"},    rd_data_b[63:32], d1);
    check({tag, ".n0"},    rd_data_n[31:0],  n0);
    check({tag, ".n1"},    rd_data_n[63:32], n1);
    check({tag, ".b0"},    32'(rd_busy_b[0]), 32'(b0));
    check({tag, ".b1"},    32'(rd_busy_b[1]), 32'(b1));
    check({tag, ".nb0"},   32'(rd_busy_n[0]), 32'(b0));
    check({tag, ".nb1"},   32'(rd_busy_n[1]), 32'(b1));
    check({tag, ".cnt"},   32'(busy_cnt_b),   32'(cnt));
    check({tag, ".ncnt"},  32'(busy_cnt_n),   32'(cnt));
  endtask

  initial begin
    //          ra0    ra1    we    wa     wd            ss    sa     d0            d1            n0            n1            b0    b1    cnt
    vecs[0]  = '{5'd5,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[1]  = '{5'd5,  5'd29, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hDEADBEEF, 32'h400,      32'hDEADBEEF, 32'h400,      1'b0, 1'b0, 6'd0};
    vecs[2]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[3]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[4]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[5]  = '{5'd8,  5'd8,  1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[6]  = '{5'd8,  5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
    vecs[7]  = '{5'd9,  5'd8,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 6'd2};
    vecs[8]  = '{5'd8,  5'd9,  1'b1, 5'd8,  32'hA5A50008, 1'b0, 5'd0,  32'hA5A50008, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 6'd2};
    vecs[9]  = '{5'd8,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hA5A50008, 32'h0,        32'hA5A50008, 32'h0,        1'b0, 1'b1, 6'd1};
    vecs[10] = '{5'd10, 5'd10, 1'b1, 5'd10, 32'h10101010, 1'b1, 5'd10, 32'h10101010, 32'h10101010, 32'h0,        32'h0,        1'b0, 1'b0, 6'd1};
    vecs[11] = '{5'd10, 5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h10101010, 32'h0,        32'h10101010, 32'h0,        1'b1, 1'b1, 6'd2};
    vecs[12] = '{5'd3,  5'd9,  1'b1, 5'd9,  32'h00000099, 1'b1, 5'd3,  32'h0,        32'h99,       32'h0,        32'h0,        1'b0, 1'b0, 6'd2};
    vecs[13] = '{5'd3,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h99,       32'h0,        32'h99,       1'b1, 1'b0, 6'd2};

    reset = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset image on every address, ports reading opposite ends of the file.
    for (int a = 0; a < 32; a++) begin
      logic [31:0] e0, e1;
      rd_addr = {5'(31 - a), 5'(a)};
      e0 = (a == 29) ? 32'h400 : 32'h0;
      e1 = ((31 - a) == 29) ? 32'h400 : 32'h0;
      @(negedge clk);
      check_all($sformatf("rst_a%0d", a), e0, e1, e0, e1, 1'b0, 1'b0, 6'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 14; i++) begin
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      wr_en   = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      sb_set  = vecs[i].ss; sb_addr = vecs[i].sa;
      @(negedge clk);
      check_all($sformatf("v%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].n0, vecs[i].n1,
                vecs[i].b0, vecs[i].b1, vecs[i].cnt);
      @(posedge clk); #1;
    end

    // Reset beats a simultaneous write to a pending register and a new sb_set.
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33333333;
    sb_set = 1'b1; sb_addr = 5'd4;
    rd_addr = {5'd29, 5'd3};
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    check_all("rstwr", 32'h0, 32'h400, 32'h0, 32'h400, 1'b0, 1'b0, 6'd0);
    rd_addr = {5'd9, 5'd4};
    #1;
    check_all("rstwr2", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;

    // Fill the scoreboard to its maximum count.
    for (int i = 1; i < 32; i++) begin
      sb_set = 1'b1; sb_addr = 5'(i);
      @(posedge clk); #1;
    end
    sb_set = 1'b1; sb_addr = 5'd1;
    rd_addr = {5'd1, 5'd31};
    @(negedge clk);
    check_all("full", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd31);
    @(posedge clk); #1;
    idle();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h7;
    @(negedge clk);
    check_all("full_set_again", 32'h7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd31);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check_all("full_clr", 32'h7, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, 6'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_mp
